// File: rtl/window_framer_pkg.sv
// Shared constants and state encoding for the overlapped window framer and
// the overlap-add blocks that consume its windows.
package window_framer_pkg;

  localparam int WORD_LENGTH = 16;
  localparam int BUS_SIZE    = 4 * WORD_LENGTH;
  localparam int HALF_BEATS  = 128;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Address width for a table of 'depth' entries, never narrower than one bit.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/window_halfbuf.sv
// Two-bank half-window store: one write port, one asynchronous read port,
// each with its own bank select. Contents are never reset; the framer masks
// stale data instead.
module window_halfbuf
  import window_framer_pkg::*;
#(
  parameter int busSize   = BUS_SIZE,
  parameter int halfBeats = HALF_BEATS,
  localparam int AW       = addrWidth(halfBeats)
) (
  input  logic               clock,
  input  logic               wrEn,
  input  logic               wrBank,
  input  logic [AW-1:0]      wrAddr,
  input  logic [busSize-1:0] wrData,
  input  logic               rdBank,
  input  logic [AW-1:0]      rdAddr,
  output logic [busSize-1:0] rdData
);

  logic [busSize-1:0] bank0 [halfBeats];
  logic [busSize-1:0] bank1 [halfBeats];

  // Write the accepted beat into the selected bank.
  always_ff @(posedge clock) begin
    if (wrEn) begin
      if (wrBank) bank1[wrAddr] <= wrData;
      else        bank0[wrAddr] <= wrData;
    end
  end

  assign rdData = rdBank ? bank1[rdAddr] : bank0[rdAddr];

endmodule

// File: rtl/window_framer.sv
// Splits a PCM beat stream into 50%-overlapped windows: each window is the
// previous half followed by the current half, so every half leaves twice.
// The first window after reset or flush has an all-zero previous half.
module window_framer
  import window_framer_pkg::*;
#(
  parameter int wordLength = WORD_LENGTH,
  parameter int busSize    = 4 * wordLength,
  parameter int halfBeats  = HALF_BEATS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [busSize-1:0] dataBusIn,
  output logic               ready,
  input  logic               flush,
  input  logic               action,
  output logic               valid,
  output logic [busSize-1:0] dataBusOut,
  output logic               first,
  output logic               last
);

  localparam int AW = addrWidth(halfBeats);
  localparam int IW = addrWidth(2 * halfBeats);
  localparam logic [AW-1:0] WR_LAST = AW'(halfBeats - 1);
  localparam logic [IW-1:0] RD_LAST = IW'(2 * halfBeats - 1);
  localparam logic [IW-1:0] HALF    = IW'(halfBeats);

  state_t             state;
  logic [AW-1:0]      wrCnt;
  logic [IW-1:0]      rdCnt;
  logic               primed;
  logic               bankSel;
  logic               wrEn;
  logic [IW-1:0]      rdIdx;
  logic               prevHalf;
  logic [AW-1:0]      rdAddr;
  logic [busSize-1:0] bufData;
  logic [busSize-1:0] nextBeat;

  assign ready = (state == FILL);
  assign wrEn  = ready && load && !flush;

  // Select the window beat to load into the output register on the next
  // accept: beat 0 while filling, otherwise the beat after the one shown.
  always_comb begin
    rdIdx    = (state == EMIT) ? rdCnt + IW'(1) : '0;
    prevHalf = (rdIdx < HALF);
    rdAddr   = AW'(prevHalf ? rdIdx : rdIdx - HALF);
    nextBeat = (prevHalf && !primed) ? '0 : bufData;
  end

  window_halfbuf #(
    .busSize  (busSize),
    .halfBeats(halfBeats)
  ) u_halfbuf (
    .clock (clock),
    .wrEn  (wrEn),
    .wrBank(bankSel),
    .wrAddr(wrCnt),
    .wrData(dataBusIn),
    .rdBank(prevHalf ? ~bankSel : bankSel),
    .rdAddr(rdAddr),
    .rdData(bufData)
  );

  // FILL/EMIT sequencing, counters and the registered output beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      wrCnt      <= '0;
      rdCnt      <= '0;
      primed     <= 1'b0;
      bankSel    <= 1'b0;
      valid      <= 1'b0;
      first      <= 1'b0;
      last       <= 1'b0;
      dataBusOut <= '0;
    end else if (flush) begin
      state      <= FILL;
      wrCnt      <= '0;
      rdCnt      <= '0;
      primed     <= 1'b0;
      valid      <= 1'b0;
      first      <= 1'b0;
      last       <= 1'b0;
      dataBusOut <= '0;
    end else if (state == FILL) begin
      if (load) begin
        if (wrCnt == WR_LAST) begin
          wrCnt      <= '0;
          rdCnt      <= '0;
          state      <= EMIT;
          valid      <= 1'b1;
          first      <= 1'b1;
          last       <= (RD_LAST == '0);
          dataBusOut <= nextBeat;
        end else begin
          wrCnt <= wrCnt + AW'(1);
        end
      end
    end else if (action) begin
      if (rdCnt == RD_LAST) begin
        state      <= FILL;
        rdCnt      <= '0;
        bankSel    <= ~bankSel;
        primed     <= 1'b1;
        valid      <= 1'b0;
        first      <= 1'b0;
        last       <= 1'b0;
        dataBusOut <= '0;
      end else begin
        rdCnt      <= rdCnt + IW'(1);
        first      <= 1'b0;
        last       <= (rdIdx == RD_LAST);
        dataBusOut <= nextBeat;
      end
    end
  end

endmodule

// File: tb/tb_window_framer.sv
// Bench for window_framer with four-beat halves. A queue-based model builds
// each expected window from the accepted beats and compares every cycle.
module tb_window_framer;

  localparam int WL = 16;
  localparam int BS = 4 * WL;
  localparam int HB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          load;
  logic [BS-1:0] dataBusIn;
  logic          ready;
  logic          flush;
  logic          action;
  logic          valid;
  logic [BS-1:0] dataBusOut;
  logic          first;
  logic          last;

  int nTests = 0;
  int nFail  = 0;

  // Reference model state
  logic [BS-1:0] fillQ [$];
  logic [BS-1:0] prevQ [$];
  logic [BS-1:0] winQ  [$];
  logic          primed = 1'b0;

  window_framer #(
    .wordLength(WL),
    .busSize   (BS),
    .halfBeats (HB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .dataBusIn (dataBusIn),
    .ready     (ready),
    .flush     (flush),
    .action    (action),
    .valid     (valid),
    .dataBusOut(dataBusOut),
    .first     (first),
    .last      (last)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [BS-1:0] got, input logic [BS-1:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelClear();
    fillQ.delete();
    winQ.delete();
    primed = 1'b0;
  endfunction

  // One clock: present inputs, check the outputs currently shown, advance the
  // model by what the coming edge does, then step to just after the edge.
  task automatic cyc(input logic ld, input logic [BS-1:0] din, input logic act,
                     input logic fl, output logic acc);
    logic emitting;
    load = ld; dataBusIn = din; action = act; flush = fl;
    emitting = (winQ.size() != 0);
    check("ready", ready, !emitting);
    check("valid", valid, emitting);
    if (emitting) begin
      check("data",  dataBusOut, winQ[0]);
      check("first", first, winQ.size() == 2 * HB);
      check("last",  last,  winQ.size() == 1);
    end else begin
      check("idle_data",  dataBusOut, '0);
      check("idle_flags", {first, last}, 2'b00);
    end
    acc = 1'b0;
    if (fl) begin
      modelClear();
    end else if (!emitting) begin
      if (ld) begin
        acc = 1'b1;
        fillQ.push_back(din);
        if (fillQ.size() == HB) begin
          for (int i = 0; i < HB; i++) winQ.push_back(primed ? prevQ[i] : '0);
          for (int i = 0; i < HB; i++) winQ.push_back(fillQ[i]);
          prevQ = fillQ;
          fillQ.delete();
        end
      end
    end else if (act) begin
      void'(winQ.pop_front());
      if (winQ.size() == 0) primed = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [BS-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  // Present one beat with load held high, draining any window in progress;
  // random data rides on load while the block is emitting and must be ignored.
  task automatic feedBeat(input logic [BS-1:0] v);
    logic acc;
    int   n = 0;
    while (winQ.size() != 0 && n < 40) begin
      cyc(1'b1, rnd(), 1'b1, 1'b0, acc);
      n++;
    end
    check("feed_bound", n < 40, 1'b1);
    cyc(1'b1, v, 1'b1, 1'b0, acc);
  endtask

  task automatic drain();
    logic acc;
    int   n = 0;
    while (winQ.size() != 0 && n < 40) begin
      cyc(1'b0, rnd(), 1'b1, 1'b0, acc);
      n++;
    end
    check("drain_bound", n < 40, 1'b1);
  endtask

  initial begin
    logic          acc;
    logic [BS-1:0] held;
    logic          heldFirst, heldLast;

    reset = 1'b0; load = 1'b0; dataBusIn = '0; flush = 1'b0; action = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_data",  dataBusOut, '0);
    check("rst_flags", {first, last}, 2'b00);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Directed: beats 1..12 give windows 0000_1234, 1234_5678, 5678_9..12
    for (int v = 1; v <= 12; v++) feedBeat(BS'(v));
    drain();

    // Output held while the consumer stalls
    for (int i = 0; i < HB; i++) feedBeat(rnd());
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    held = dataBusOut; heldFirst = first; heldLast = last;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, acc);
      check("stall_data",  dataBusOut, held);
      check("stall_flags", {first, last}, {heldFirst, heldLast});
    end
    drain();

    // Flush two beats into a half; the beat presented with flush is dropped
    feedBeat(rnd());
    feedBeat(rnd());
    cyc(1'b1, rnd(), 1'b1, 1'b1, acc);
    for (int i = 0; i < HB; i++) feedBeat(rnd());
    drain();
    for (int i = 0; i < HB; i++) feedBeat(rnd());

    // Asynchronous reset while beat 5 of the window is shown
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0, acc);
    check("pre_rst_valid", valid, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_valid", valid, 1'b0);
    check("async_rst_data",  dataBusOut, '0);
    check("async_rst_ready", ready, 1'b1);
    modelClear();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < HB; i++) feedBeat(rnd());
    drain();

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 39) == 0), acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got stuck expected done");
    $fatal(1);
  end

endmodule

// File: doc/window_framer.md
WINDOW_FRAMER -- requirements
Module: window_framer

Interface
REQ-001 The block SHALL have parameter wordLength, default 16, meaning PCM sample width in bits.
REQ-002 The block SHALL have parameter busSize, default 4*wordLength, meaning bus width (4 samples per beat, sample i at bits [(i+1)*wordLength-1 : i*wordLength]).
REQ-003 The block SHALL have parameter halfBeats, default 128, meaning beats per half-window (512 samples).
REQ-004 The block SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port load  input  1  input beat valid.
REQ-007 The block SHALL have port dataBusIn  input  busSize  input PCM beat.
REQ-008 The block SHALL have port ready  output  1  block accepts a beat this cycle.
REQ-009 The block SHALL have port flush  input  1  synchronous restart of the window sequence.
REQ-010 The block SHALL have port action  input  1  consumer accepts the current output beat.
REQ-011 The block SHALL have port valid  output  1  dataBusOut holds a window beat.
REQ-012 The block SHALL have port dataBusOut  output  busSize  output window beat, registered.
REQ-013 The block SHALL have ports first and last  output  1 each  marking beat 0 and beat 2*halfBeats-1 of a window.

Function
REQ-014 The block SHALL split a PCM stream into 50%-overlapped windows: window k = half H(k-1) followed by half H(k); each half is emitted twice, the inverse of overlap-add.
REQ-015 The block SHALL use FSM states FILL and EMIT; a beat is accepted when load && ready; ready = 1 only in FILL.
REQ-016 In FILL, the block SHALL write accepted beats into the current bank at address wrCnt (0..halfBeats-1); wrCnt wraps to 0 after halfBeats-1.
REQ-017 The block SHALL go FILL->EMIT in the cycle after the halfBeats-th beat is accepted, with valid=1, first=1, and beat 0 of the window on dataBusOut (one-cycle latency).
REQ-018 In EMIT, rdCnt 0..halfBeats-1 SHALL read the previous bank and rdCnt halfBeats..2*halfBeats-1 SHALL read the current bank, in address order.
REQ-019 The block SHALL hold dataBusOut, first, last, and valid stable while valid && !action; rdCnt advances only on valid && action.
REQ-020 On acceptance of the beat with last=1, the block SHALL return to FILL next cycle, swap bank roles (current becomes previous), and set primed=1.
REQ-021 While primed=0 (first window after reset/flush), the previous-half beats SHALL be emitted as all zeros.
REQ-022 When valid=0, dataBusOut SHALL be 0, and first and last SHALL be 0.
REQ-023 On flush, the block SHALL clear wrCnt, rdCnt, and primed, enter FILL, and deassert valid next cycle; flush overrides load and action in the same cycle, and the beat presented with it is dropped.
REQ-024 Stored samples SHALL be passed bit-exact; no arithmetic or width change.

Reset
REQ-025 On reset=0, the block SHALL asynchronously force state=FILL, wrCnt=0, rdCnt=0, primed=0, bank select=0, valid=0, first=0, last=0, dataBusOut=0; ready=1 from the first clock after release.
REQ-026 Buffer contents SHALL need no reset; primed=0 guarantees stale data is never emitted.
REQ-027 Reset asserted mid-FILL or mid-EMIT SHALL discard the partial half/window; the next window after release is a first window.

Structure
REQ-028 The shared package SHALL hold WORD_LENGTH, BUS_SIZE, HALF_BEATS, and the FILL/EMIT state encoding; overlap consumers SHALL use the same constants.
REQ-029 One sub-module, window_halfbuf, SHALL implement a two-bank halfBeats x busSize storage with one write port and one read port plus bank select; window_framer holds the FSM, counters, and output register.

Verification (halfBeats=4)
REQ-030 After reset, feed beats 1..4 with action=1: the bench SHALL see valid window 0,0,0,0,1,2,3,4, first on beat 0, last on beat 7, and ready=0 throughout EMIT.
REQ-031 Then feed 5..8: the bench SHALL see window 1,2,3,4,5,6,7,8; then feed 9..12: window 5..12.
REQ-032 With action=0 for 3 cycles mid-window: the bench SHALL see dataBusOut/first/last held and no beats skipped or duplicated.
REQ-033 Assert flush after 2 beats of the second half: the bench SHALL see the next window begin with four zero beats, and beats before flush SHALL never appear.
REQ-034 Drive reset low during EMIT beat 5: the bench SHALL see valid=0 and dataBusOut=0 immediately, and the next window SHALL be zero-prefixed.
REQ-035 With load held at 1 during EMIT: the bench SHALL see no beats accepted (ready=0) and window contents unaffected.
